// File: rtl/pwm_decoder_pkg.sv
// Shared constants for the PWM decoder: state encoding, nominal period and
// no-edge timeout, both derived from data_size.
package pwm_decoder_pkg;

  localparam int DATA_SIZE_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  function automatic int pwm_period(input int ds);
    return 1 << (ds + 1);
  endfunction

  // One cycle longer than a legal period, so a silent line is caught after P+1.
  function automatic int pwm_timeout(input int ds);
    return pwm_period(ds) + 1;
  endfunction

  localparam int P_DEF       = pwm_period(DATA_SIZE_DEF);
  localparam int TIMEOUT_DEF = pwm_timeout(DATA_SIZE_DEF);

endpackage

// File: rtl/pwm_edge_detect.sv
// Input conditioning for the PWM decoder: optional 2-flop synchronizer
// (PWM_DECODER_SYNC_EN), level register s, delayed copy s_d, rise/fall strobes.
module pwm_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm_in,
  output logic o_rise,
  output logic o_fall
);

  logic w_in;
  logic r_s;
  logic r_s_d;

`ifdef PWM_DECODER_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[0], i_pwm_in};
  end

  assign w_in = r_sync[1];
`else
  assign w_in = i_pwm_in;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s   <= 1'b0;
      r_s_d <= 1'b0;
    end else begin
      r_s   <= w_in;
      r_s_d <= r_s;
    end
  end

  assign o_rise = r_s & ~r_s_d;
  assign o_fall = ~r_s & r_s_d;

endmodule

// File: rtl/pwm_decoder.sv
// Receive-side PWM decoder: measures high time and rise-to-rise period,
// publishes the recovered code with a valid strobe, flags bad periods and a stuck-high line.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int data_size = DATA_SIZE_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pwm_in,
  output logic [data_size:0] o_rate,
  output logic               o_valid,
  output logic               o_period_err,
  output logic               o_stuck_high
);

  localparam int W  = data_size + 1;
  localparam int P  = pwm_period(data_size);
  localparam int TO = pwm_timeout(data_size);

  localparam logic [W:0] P_C   = P[W:0];
  localparam logic [W:0] TO_C  = TO[W:0];
  localparam logic [W:0] ONE_C = {{W{1'b0}}, 1'b1};

  logic w_rise;
  logic w_fall;

  state_e         r_state, w_state_nxt;
  logic [W:0]     r_hcnt,  w_hcnt_nxt;
  logic [W:0]     r_tcnt,  w_tcnt_nxt;
  logic [W-1:0]   r_rate,  w_rate_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_err,   w_err_nxt;
  logic           r_stuck, w_stuck_nxt;
  logic [W:0]     w_tinc;
  logic [W:0]     w_hinc;

  pwm_edge_detect u_edge (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_pwm_in (i_pwm_in),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_tinc = (r_tcnt == TO_C) ? r_tcnt : r_tcnt + 1'b1;
  assign w_hinc = r_hcnt + 1'b1;

  // Timeouts fire on the cycle the count would reach P+1; tcnt may already sit
  // saturated after a stuck-high episode, hence the >= compares.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_tcnt_nxt  = w_tinc;
    w_rate_nxt  = r_rate;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_stuck_nxt = r_stuck;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_hcnt_nxt  = ONE_C;
          w_tcnt_nxt  = ONE_C;
          w_state_nxt = HIGH;
        end else if (r_tcnt >= P_C) begin
          w_rate_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_tcnt_nxt  = '0;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_stuck_nxt = 1'b0;
          w_state_nxt = LOW;
        end else if (r_hcnt != P_C) begin
          w_hcnt_nxt = w_hinc;
          if (w_hinc == P_C) w_stuck_nxt = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          if (r_tcnt == P_C) begin
            w_rate_nxt  = r_hcnt[W-1:0];
            w_valid_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_hcnt_nxt  = ONE_C;
          w_tcnt_nxt  = ONE_C;
          w_state_nxt = HIGH;
        end else if (r_tcnt >= P_C) begin
          w_rate_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_tcnt_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_tcnt  <= '0;
      r_rate  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_stuck <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_rate  <= w_rate_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_stuck <= w_stuck_nxt;
    end
  end

  assign o_rate       = r_rate;
  assign o_valid      = r_valid;
  assign o_period_err = r_err;
  assign o_stuck_high = r_stuck;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder (data_size=3, P=16); expected timings shift by
// two cycles when built with PWM_DECODER_SYNC_EN.
module tb_pwm_decoder;

  localparam int DS = 3;
  localparam int W  = DS + 1;
`ifdef PWM_DECODER_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] rate;
  logic         valid;
  logic         perr;
  logic         stuck;

  pwm_decoder #(.data_size(DS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pwm_in     (pwm_in),
    .o_rate       (rate),
    .o_valid      (valid),
    .o_period_err (perr),
    .o_stuck_high (stuck)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Pattern generator: high for gen_high of every gen_per cycles; new settings
  // are latched only at a period boundary so transitions stay clean.
  bit gen_on   = 1'b0;
  int gen_cnt  = 0;
  int gen_high = 0;
  int gen_per  = 16;
  int nxt_high = 0;
  int nxt_per  = 16;
  int cyc      = 0;
  int rise_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (!gen_on) pwm_in = 1'b0;
    else begin
      if (gen_cnt == 0) begin
        gen_high = nxt_high;
        gen_per  = nxt_per;
      end
      if (gen_cnt < gen_high && !pwm_in) rise_cyc = cyc;
      pwm_in  = (gen_cnt < gen_high);
      gen_cnt = (gen_cnt + 1 >= gen_per) ? 0 : gen_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_gen(input int h, input int p);
    gen_on = 1'b0;
    rst    = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    nxt_high = h;
    nxt_per  = p;
    gen_cnt  = 0;
    gen_on   = 1'b1;
  endtask

  typedef struct {
    int high;
    int per;
    int n;
    int exp_rate;
    int exp_valid;
    int exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nv, ne, both, st, mism, first_st, vtick, vrate, guard, rel, r1, seen3, inter, bad, n3;

    vecs[0] = '{5,  16, 104, 5,  6, 0};
    vecs[1] = '{0,  16, 104, 0,  6, 0};
    vecs[2] = '{15, 16, 104, 15, 6, 0};
    vecs[3] = '{8,  16, 104, 8,  6, 0};
    vecs[4] = '{1,  16, 104, 1,  6, 0};
    vecs[5] = '{4,  13, 104, 0,  0, 7};

    repeat (2) tick();
    chk("reset_rate",  int'(rate),  0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_perr",  int'(perr),  0);
    chk("reset_stuck", int'(stuck), 0);

    for (int i = 0; i < 6; i++) begin
      start_gen(vecs[i].high, vecs[i].per);
      nv = 0; ne = 0; both = 0; st = 0;
      repeat (vecs[i].n) begin
        tick();
        if (valid) nv++;
        if (perr) ne++;
        if (valid && perr) both++;
        if (stuck) st++;
      end
      chk($sformatf("row%0d_rate", i),    int'(rate), vecs[i].exp_rate);
      chk($sformatf("row%0d_valids", i),  nv,         vecs[i].exp_valid);
      chk($sformatf("row%0d_perrs", i),   ne,         vecs[i].exp_err);
      chk($sformatf("row%0d_overlap", i), both,       0);
      chk($sformatf("row%0d_stuck", i),   st,         0);
    end

    // Step from 15 to 3: at most one odd value, then only 3.
    start_gen(15, 16);
    repeat (40) tick();
    chk("step_rate15", int'(rate), 15);
    nxt_high = 3;
    seen3 = 0; inter = 0; bad = 0; n3 = 0;
    repeat (100) begin
      tick();
      if (valid) begin
        if (rate == 3) begin seen3 = 1; n3++; end
        else if (seen3 != 0) bad++;
        else if (rate != 15) inter++;
      end
    end
    chk("step_after3_other", bad, 0);
    chk("step_intermediate_le1", int'(inter <= 1), 1);
    chk("step_n3_ge4", int'(n3 >= 4), 1);
    chk("step_rate3", int'(rate), 3);

    // Bad period after a good code: errors every 13, rate held.
    start_gen(5, 16);
    repeat (40) tick();
    chk("p13_prior_rate", int'(rate), 5);
    nxt_high = 4;
    nxt_per  = 13;
    repeat (24) tick();
    nv = 0; ne = 0;
    repeat (52) begin
      tick();
      if (valid) nv++;
      if (perr) ne++;
    end
    chk("p13_valids", nv, 0);
    chk("p13_perrs",  ne, 4);
    chk("p13_rate",   int'(rate), 5);

    // Held high 20 cycles: stuck_high window, then rate=0 timeout.
    start_gen(20, 200);
    mism = 0; first_st = -1; vtick = -1; vrate = -1; nv = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (int'(stuck) != int'(k >= 18 + EXTRA && k <= 22 + EXTRA)) mism++;
      if (stuck && first_st < 0) first_st = k;
      if (valid) begin
        nv++;
        if (vtick < 0) begin vtick = k; vrate = int'(rate); end
      end
    end
    chk("stuck_profile",   mism,     0);
    chk("stuck_set_tick",  first_st, 18 + EXTRA);
    chk("stuck_tmo_tick",  vtick,    24 + EXTRA);
    chk("stuck_tmo_rate",  vrate,    0);
    chk("stuck_tmo_count", nv,       1);

    // Reset mid-HIGH at rate 9, release in the low phase.
    start_gen(9, 16);
    repeat (40) tick();
    chk("rst9_prior_rate", int'(rate), 9);
    guard = 0;
    while (gen_cnt != 6 && guard < 40) begin tick(); guard++; end
    rst = 1'b1;
    #1;
    chk("rst9_rate",  int'(rate),  0);
    chk("rst9_valid", int'(valid), 0);
    chk("rst9_perr",  int'(perr),  0);
    chk("rst9_stuck", int'(stuck), 0);
    guard = 0;
    while (gen_cnt != 12 && guard < 40) begin tick(); guard++; end
    rst = 1'b0;
    rel = cyc;
    guard = 0;
    while (rise_cyc <= rel && guard < 40) begin tick(); guard++; end
    r1 = rise_cyc;
    vtick = -1; vrate = -1; ne = 0;
    guard = 0;
    while (vtick < 0 && guard < 60) begin
      tick();
      guard++;
      if (perr) ne++;
      if (valid) begin vtick = cyc; vrate = int'(rate); end
    end
    chk("rst9_latency", vtick - r1, 18 + EXTRA);
    chk("rst9_rate_after", vrate, 9);
    chk("rst9_perr_after", ne, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
